wait_state_mem: RTL and testbench



---
 rtl/wait_state_mem.sv | 135 +++++++++++++
 tb/tb_wait_state_mem.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_mem.sv
// Single-port memory model with request/ready handshake, programmable read/write
// wait states, a write-protected ROM window and open-bus reads for unmapped addresses.
module wait_state_mem #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8192,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned WR_LAT    = 1,
  parameter int unsigned ROM_SIZE  = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              err
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ROM_L   = (ADDR_W+1)'(ROM_SIZE);
  localparam logic [3:0]      RD_CNT  = 4'(RD_LAT - 1);
  localparam logic [3:0]      WR_CNT  = 4'(WR_LAT - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                wack_q, wack_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                mapped;
  logic                wr_ok;
  logic [IDX_W-1:0]    idx;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign idx    = addr_q[IDX_W-1:0];
  assign mapped = ({1'b0, addr_q} < DEPTH_L);
  assign wr_ok  = mapped && ({1'b0, addr_q} >= ROM_L);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wack_d   = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = we ? WR_CNT : RD_CNT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (we_q) begin
            wack_d = 1'b1;
            err_d  = !wr_ok;
            // rst gating covers a reset edge coinciding with the completing clock edge
            mem_we = wr_ok && !rst;
          end else begin
            rvalid_d = 1'b1;
            err_d    = !mapped;
            rdata_d  = mapped ? mem_q[idx] : '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      err_q    <= err_d;
    end
  end

  // Array has no reset so contents survive rst and can map onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign ready  = (state_q == IDLE);
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wack   = wack_q;
  assign err    = err_q;

endmodule

// File: tb/tb_wait_state_mem.sv
// Self-checking bench for wait_state_mem: vector table, scoreboard of expected
// completions, plus latency, busy-input-change, reset-abort and back-to-back sequences.
module tb_wait_state_mem;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        wack;
  logic        err;

  wait_state_mem #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .DEPTH   (8192),
    .RD_LAT  (RD_LAT),
    .WR_LAT  (WR_LAT),
    .ROM_SIZE(256)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .rdata (rdata),
    .rvalid(rvalid),
    .wack  (wack),
    .err   (err)
  );

  typedef struct packed {
    logic       is_wr;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  ed;
    logic        ee;
  } vec_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         cyc = 0;
  int         last_rv_cyc = -1;
  logic       b2b = 1'b0;
  logic [7:0] last_rd = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp_v);
    n_checks++;
    n_err++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Completion monitor: pops the scoreboard on every done pulse
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (err && !rvalid && !wack) fail("err_without_done", 1, 0);
    if (rvalid || wack) begin
      n_done++;
      if (rvalid && wack) fail("rvalid_and_wack", 1, 0);
      if (sb.size() == 0) begin
        fail("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_kind", {31'd0, wack}, {31'd0, e.is_wr});
        if (!e.is_wr) begin
          check("rdata", {24'd0, rdata}, {24'd0, e.rdata});
          last_rd = e.rdata;
          if (b2b) begin
            if (last_rv_cyc >= 0) check("rvalid_spacing", cyc - last_rv_cyc, RD_LAT + 1);
            last_rv_cyc = cyc;
          end
        end else begin
          check("rdata_hold", {24'd0, rdata}, {24'd0, last_rd});
        end
        check("err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) fail("ready_timeout", guard, 50);
  endtask

  task automatic wait_done(input int prev);
    int guard = 0;
    while (n_done == prev && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (n_done == prev) fail("done_timeout", guard, 40);
  endtask

  task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] ed, input logic ee);
    int prev;
    @(negedge clk);
    wait_ready();
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sb.push_back('{w, ed, ee});
    prev = n_done;
    @(negedge clk);
    req = 1'b0;
    we  = 1'b0;
    wait_done(prev);
  endtask

  vec_t vecs[15];
  logic [15:0] b2b_addr[4];
  logic [7:0]  b2b_data[4];
  logic        b2b_err[4];

  initial begin
    int prev;
    int t0;

    vecs[0]  = '{1'b0, 16'h0010, 8'h00, 8'h3E, 1'b0};
    vecs[1]  = '{1'b1, 16'h0200, 8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 16'h0200, 8'h00, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 16'h0050, 8'h77, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 16'h0050, 8'h00, 8'h12, 1'b0};
    vecs[5]  = '{1'b0, 16'h3000, 8'h00, 8'hFF, 1'b1};
    vecs[6]  = '{1'b1, 16'h3000, 8'h5A, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 16'h1000, 8'h00, 8'hC3, 1'b0};
    vecs[8]  = '{1'b1, 16'h00FF, 8'h11, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 16'h0100, 8'h22, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 16'h0100, 8'h00, 8'h22, 1'b0};
    vecs[11] = '{1'b0, 16'h1FFF, 8'h00, 8'h9D, 1'b0};
    vecs[12] = '{1'b0, 16'h2000, 8'h00, 8'hFF, 1'b1};
    vecs[13] = '{1'b1, 16'h1FFF, 8'h44, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 16'h1FFF, 8'h00, 8'h44, 1'b0};

    b2b_addr = '{16'h0010, 16'h0200, 16'h1000, 16'h2000};
    b2b_data = '{8'h3E, 8'hA5, 8'hC3, 8'hFF};
    b2b_err  = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Stands in for an INIT_FILE image
    dut.mem_q[16]   = 8'h3E;
    dut.mem_q[80]   = 8'h12;
    dut.mem_q[769]  = 8'h5C;
    dut.mem_q[4096] = 8'hC3;
    dut.mem_q[8191] = 8'h9D;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'd0, ready},  32'd1);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_wack",   {31'd0, wack},   32'd0);
    check("rst_err",    {31'd0, err},    32'd0);
    check("rst_rdata",  {24'd0, rdata},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd1);

    // Read latency
    req = 1'b1; we = 1'b0; addr = 16'h0010;
    sb.push_back('{1'b0, 8'h3E, 1'b0});
    prev = n_done;
    @(posedge clk);
    #1;
    t0 = cyc;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 20 && n_done == prev; i++) begin
      check("ready_low_busy", {31'd0, ready}, 32'd0);
      @(negedge clk);
    end
    if (n_done == prev) fail("latency_timeout", 0, 1);
    check("read_latency", cyc - t0, RD_LAT);
    check("ready_done_cycle", {31'd0, ready}, 32'd1);
    @(negedge clk);
    check("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);

    // Inputs changed while BUSY must not reach the array
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 16'h0300; wdata = 8'h66;
    sb.push_back('{1'b1, 8'h00, 1'b0});
    prev = n_done;
    @(negedge clk);
    check("wr_busy_ready", {31'd0, ready}, 32'd0);
    we = 1'b0; addr = 16'h0301; wdata = 8'hEE;
    @(negedge clk);
    req = 1'b0;
    wait_done(prev);
    do_access(1'b0, 16'h0300, 8'h00, 8'h66, 1'b0);
    do_access(1'b0, 16'h0301, 8'h00, 8'h5C, 1'b0);

    for (int i = 0; i < 15; i++) begin
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].ed, vecs[i].ee);
    end

    // Reset mid-read: the transaction vanishes
    @(negedge clk);
    wait_ready();
    req = 1'b1; we = 1'b0; addr = 16'h0010;
    prev = n_done;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_rvalid", n_done, prev);

    // Back-to-back reads with req held high
    b2b = 1'b1;
    last_rv_cyc = -1;
    req = 1'b1; we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr = b2b_addr[k];
      sb.push_back('{1'b0, b2b_data[k], b2b_err[k]});
      check("b2b_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      check("b2b_busy", {31'd0, ready}, 32'd0);
      repeat (RD_LAT) @(negedge clk);
    end
    req = 1'b0;
    repeat (4) @(negedge clk);
    b2b = 1'b0;

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
